// File: rtl/router_src_ingress_if.sv
// Source/destination bus bundle for router_src_ingress.
// Carries the source byte stream with its busy back-pressure, plus the shared
// destination FIFO write bus and the per-destination full flags.
//   data_in   : header/payload/parity byte from the source
//   pkt_valid : 1 = header or payload byte, 0 with a packet in flight = parity byte
//   busy      : 1 = no byte accepted this cycle, source holds its byte
//   dout      : byte presented to the destination FIFOs
//   wr_en     : one-hot write strobe, bit index = destination address
//   fifo_full : per-destination full flag
// Modports: master = source/FIFO environment, slave = ingress controller.
interface router_src_ingress_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 3
);
    logic [DATA_W-1:0]    data_in;
    logic                 pkt_valid;
    logic                 busy;
    logic [DATA_W-1:0]    dout;
    logic [NUM_PORTS-1:0] wr_en;
    logic [NUM_PORTS-1:0] fifo_full;

    modport master (
        output data_in, pkt_valid, fifo_full,
        input  busy, dout, wr_en
    );

    modport slave (
        input  data_in, pkt_valid, fifo_full,
        output busy, dout, wr_en
    );
endinterface

// File: rtl/router_src_ingress.sv
// Ingress controller for the router source port. Accepts header/payload/parity
// packets, routes every byte (parity included) to one of NUM_PORTS destination
// FIFOs through a single-entry hold register, checks parity and length, and
// silently discards packets whose address is out of range.
// Ports:
//   clock    : single clock, rising edge
//   resetn   : asynchronous active-low reset
//   bus      : router_src_ingress_if.slave (data_in, pkt_valid, busy, dout,
//              wr_en, fifo_full)
//   err      : one-cycle pulse, parity or length mismatch on a routed packet
//   drop     : one-cycle pulse, out-of-range packet fully discarded
//   pkt_done : one-cycle pulse, cycle after a routed packet's parity byte is written
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a header (pkt_valid=1); pkt_valid=0 ignored
// LOAD  | routing payload bytes; a pkt_valid=0 byte is the parity
// CHECK | one cycle after parity acceptance, nothing accepted
// DROP  | consuming an out-of-range packet without writes
module router_src_ingress #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int NUM_PORTS = 3
) (
    input  logic                 clock,
    input  logic                 resetn,
    router_src_ingress_if.slave  bus,
    output logic                 err,
    output logic                 drop,
    output logic                 pkt_done
);
    localparam int LEN_W = DATA_W - ADDR_W;
    // One extra bit over the length field so an over-long packet is still
    // distinguishable from a correct one after saturation.
    localparam int CNT_W = LEN_W + 1;
    localparam logic [ADDR_W:0] PORT_LIMIT = (ADDR_W+1)'(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DROP} state_t;

    state_t               state;
    state_t               state_nxt;

    logic                 hold_valid;
    logic [DATA_W-1:0]    hold_byte;
    logic [ADDR_W-1:0]    hold_addr;
    logic                 hold_last;

    logic [ADDR_W-1:0]    cur_addr;
    logic [LEN_W-1:0]     len_reg;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_W-1:0]    parity_acc;

    logic [ADDR_W-1:0]    hdr_addr;
    logic [LEN_W-1:0]     hdr_len;
    logic                 hdr_addr_ok;
    logic [NUM_PORTS-1:0] hold_sel;
    logic                 full_sel;
    logic                 busy_int;
    logic                 wr_fire;

    logic                 hdr_take;
    logic                 pay_take;
    logic                 par_take;
    logic                 drop_end;
    logic                 hold_load;

    assign hdr_addr    = bus.data_in[ADDR_W-1:0];
    assign hdr_len     = bus.data_in[DATA_W-1:ADDR_W];
    assign hdr_addr_ok = ({1'b0, hdr_addr} < PORT_LIMIT);

    always_comb begin
        hold_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            hold_sel[i] = (hold_addr == ADDR_W'(i));
        end
    end

    // Only the full flag of the destination currently in hold matters.
    assign full_sel = |(bus.fifo_full & hold_sel);
    assign busy_int = hold_valid && full_sel;
    assign wr_fire  = hold_valid && !full_sel;

    assign bus.busy  = busy_int;
    // Strobe is decoded from the hold register and gated by the live full
    // flag so a full FIFO is never written.
    assign bus.wr_en = wr_fire ? hold_sel : '0;
    assign bus.dout  = hold_byte;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hdr_take  = 1'b0;
        pay_take  = 1'b0;
        par_take  = 1'b0;
        drop_end  = 1'b0;
        hold_load = 1'b0;
        case (state)
            IDLE: begin
                if (bus.pkt_valid && !busy_int) begin
                    hdr_take  = 1'b1;
                    hold_load = hdr_addr_ok;
                    state_nxt = hdr_addr_ok ? LOAD : DROP;
                end
            end
            LOAD: begin
                if (!busy_int) begin
                    hold_load = 1'b1;
                    if (bus.pkt_valid) begin
                        pay_take = 1'b1;
                    end else begin
                        par_take  = 1'b1;
                        state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                state_nxt = IDLE;
            end
            DROP: begin
                if (!busy_int && !bus.pkt_valid) begin
                    drop_end  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hold_valid <= 1'b0;
            hold_byte  <= '0;
            hold_addr  <= '0;
            hold_last  <= 1'b0;
            cur_addr   <= '0;
            len_reg    <= '0;
            cnt        <= '0;
            parity_acc <= '0;
            err        <= 1'b0;
            drop       <= 1'b0;
            pkt_done   <= 1'b0;
        end else begin
            // Refill wins over drain: a write and a new byte in the same
            // cycle keep hold_valid set.
            if (hold_load) begin
                hold_valid <= 1'b1;
                hold_byte  <= bus.data_in;
                hold_addr  <= hdr_take ? hdr_addr : cur_addr;
                hold_last  <= !bus.pkt_valid;
            end else if (wr_fire) begin
                hold_valid <= 1'b0;
            end

            if (hdr_take) begin
                cur_addr   <= hdr_addr;
                len_reg    <= hdr_len;
                cnt        <= '0;
                parity_acc <= bus.data_in;
            end else if (pay_take) begin
                cnt        <= (cnt == '1) ? cnt : cnt + 1'b1;
                parity_acc <= parity_acc ^ bus.data_in;
            end

            err      <= par_take && ((bus.data_in != parity_acc) ||
                                     (cnt != {1'b0, len_reg}));
            drop     <= drop_end;
            pkt_done <= wr_fire && hold_last;
        end
    end
endmodule

// File: tb/tb_router_src_ingress.sv
module tb_router_src_ingress;
    logic clock  = 1'b0;
    logic resetn = 1'b0;
    logic err;
    logic drop;
    logic pkt_done;

    always #5 clock = ~clock;

    router_src_ingress_if #(.DATA_W(8), .NUM_PORTS(3)) bus ();

    router_src_ingress #(.DATA_W(8), .ADDR_W(2), .NUM_PORTS(3)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .bus      (bus),
        .err      (err),
        .drop     (drop),
        .pkt_done (pkt_done)
    );

    typedef struct packed {
        logic [2:0] mask;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         err_cnt = 0;
    int         drop_cnt = 0;
    int         done_cnt = 0;
    int         busy_cycles = 0;
    int         wr_seen = 0;
    int         first_wr = -1;
    int         last_wr = -1;
    int         acc_cyc = 0;
    int         hdr_cyc = 0;
    int         b0 = 0;
    int         w0 = 0;
    logic [2:0] stall_mask = 3'b000;
    logic [2:0] base_mask = 3'b000;
    int         stall_left = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples after all stimulus for the cycle has settled.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (resetn) begin
                if (bus.wr_en != 3'b000) begin
                    if (first_wr < 0) first_wr = cyc;
                    last_wr = cyc;
                    wr_seen++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_wr", 32'({bus.wr_en, bus.dout}), 32'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("wr_port", 32'(bus.wr_en), 32'(mon_e.mask));
                        check("wr_data", 32'(bus.dout), 32'(mon_e.data));
                    end
                end
                if (err)      err_cnt++;
                if (drop)     drop_cnt++;
                if (pkt_done) done_cnt++;
            end
        end
    end

    task automatic apply_full();
        if (stall_left > 0) begin
            bus.fifo_full = base_mask | stall_mask;
            stall_left--;
        end else begin
            bus.fifo_full = base_mask;
        end
    endtask

    // Drive one byte starting at a negedge, wait out busy, return at the
    // negedge after the accepting edge. port < 0 means no write expected.
    task automatic send(input logic [7:0] d, input logic v, input int port);
        int guard = 0;
        apply_full();
        bus.data_in   = d;
        bus.pkt_valid = v;
        #1;
        while (bus.busy === 1'b1 && guard < 50) begin
            busy_cycles++;
            guard++;
            @(negedge clock);
            apply_full();
            #1;
        end
        if (guard >= 50) check("busy_timeout", 32'(guard), 32'd0);
        @(posedge clock);
        acc_cyc = cyc + 1;
        if (port >= 0) exp_q.push_back({3'(1 << port), d});
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply_full();
            bus.pkt_valid = 1'b0;
            bus.data_in   = 8'h00;
            @(negedge clock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.data_in   = 8'h00;
        bus.pkt_valid = 1'b0;
        bus.fifo_full = 3'b000;
        resetn        = 1'b0;
        repeat (2) @(negedge clock);
        #3;
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_wr_en",    32'(bus.wr_en),    32'd0);
        check("rst_dout",     32'(bus.dout),     32'd0);
        check("rst_err",      32'(err),          32'd0);
        check("rst_drop",     32'(drop),         32'd0);
        check("rst_pkt_done", 32'(pkt_done),     32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Good packet to port 1, len 3
        first_wr = -1;
        wr_seen  = 0;
        send(8'h0D, 1'b1, 1);
        hdr_cyc = acc_cyc;
        send(8'h11, 1'b1, 1);
        send(8'h22, 1'b1, 1);
        send(8'h33, 1'b1, 1);
        send(8'h0D, 1'b0, 1);
        idle(3);
        check("t1_first_wr", 32'(first_wr), 32'(hdr_cyc));
        check("t1_last_wr",  32'(last_wr),  32'(hdr_cyc + 4));
        check("t1_wr_count", 32'(wr_seen),  32'd5);
        check("t1_err",      32'(err_cnt),  32'd0);
        check("t1_done",     32'(done_cnt), 32'd1);

        // Same packet, bad parity
        send(8'h0D, 1'b1, 1);
        send(8'h11, 1'b1, 1);
        send(8'h22, 1'b1, 1);
        send(8'h33, 1'b1, 1);
        send(8'hFF, 1'b0, 1);
        idle(3);
        check("t2_err",  32'(err_cnt),  32'd1);
        check("t2_done", 32'(done_cnt), 32'd2);

        // Out-of-range address 3: dropped, no writes, no busy
        b0 = busy_cycles;
        w0 = wr_seen;
        send(8'h07, 1'b1, -1);
        send(8'h9A, 1'b1, -1);
        send(8'h9D, 1'b0, -1);
        idle(3);
        check("t3_drop",   32'(drop_cnt),    32'd1);
        check("t3_busy",   32'(busy_cycles), 32'(b0));
        check("t3_writes", 32'(wr_seen),     32'(w0));
        check("t3_err",    32'(err_cnt),     32'd1);

        // Port 2 stalled 4 cycles mid-payload; other ports' full flags irrelevant
        b0 = busy_cycles;
        send(8'h0E, 1'b1, 2);
        send(8'hA1, 1'b1, 2);
        stall_mask = 3'b100;
        stall_left = 4;
        send(8'hB2, 1'b1, 2);
        base_mask = 3'b011;
        send(8'hC3, 1'b1, 2);
        send(8'hDE, 0, 2);
        idle(3);
        base_mask = 3'b000;
        check("t4_busy_cycles", 32'(busy_cycles - b0), 32'd4);
        check("t4_err",         32'(err_cnt),          32'd1);
        check("t4_done",        32'(done_cnt),         32'd3);
        check("t4_queue",       32'(exp_q.size()),     32'd0);

        // Back-to-back: port 0 parity stalled, port 2 header waits behind it
        b0 = busy_cycles;
        send(8'h04, 1'b1, 0);
        send(8'h55, 1'b1, 0);
        send(8'h51, 1'b0, 0);
        stall_mask = 3'b001;
        stall_left = 3;
        send(8'h02, 1'b1, 2);
        send(8'h02, 1'b0, 2);
        idle(3);
        check("t5_busy_cycles", 32'(busy_cycles - b0), 32'd3);
        check("t5_err",         32'(err_cnt),          32'd1);
        check("t5_done",        32'(done_cnt),         32'd5);
        check("t5_queue",       32'(exp_q.size()),     32'd0);

        // Reset mid-payload, then a clean packet
        send(8'h0D, 1'b1, 1);
        send(8'h11, 1'b1, 1);
        #3;
        resetn = 1'b0;
        #1;
        check("t6_busy",     32'(bus.busy),     32'd0);
        check("t6_wr_en",    32'(bus.wr_en),    32'd0);
        check("t6_dout",     32'(bus.dout),     32'd0);
        check("t6_err",      32'(err),          32'd0);
        check("t6_pkt_done", 32'(pkt_done),     32'd0);
        check("t6_queue",    32'(exp_q.size()), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        send(8'h0D, 1'b1, 1);
        send(8'h11, 1'b1, 1);
        send(8'h22, 1'b1, 1);
        send(8'h33, 1'b1, 1);
        send(8'h0D, 1'b0, 1);
        idle(3);
        check("t6_err_after", 32'(err_cnt),  32'd1);
        check("t6_done",      32'(done_cnt), 32'd6);
        check("t6_drop",      32'(drop_cnt), 32'd1);

        // Packet longer than its header claims: routed, but flagged
        send(8'h05, 1'b1, 1);
        send(8'h10, 1'b1, 1);
        send(8'h20, 1'b1, 1);
        send(8'h35, 1'b0, 1);
        idle(3);
        check("t7_len_err", 32'(err_cnt),      32'd2);
        check("t7_done",    32'(done_cnt),     32'd7);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
